// File: rtl/uart_rx_deframer_if.sv
// rtl/uart_rx_deframer_if.sv - serial line, oversample tick, acknowledge and received-byte status
interface uart_rx_deframer_if;
  logic       clken;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
  logic       ferr;
  logic       overrun;

  modport master (output clken, rx, rdy_clr, input data, rdy, ferr, overrun);
  modport slave  (input clken, rx, rdy_clr, output data, rdy, ferr, overrun);
endinterface

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - 16x-oversampled 8N1 receiver: start validation, mid-bit sampling, stop check
module uart_rx_deframer #(
  parameter int DATA_BITS = 8
) (
  input logic              clk,
  input logic              reset,
  uart_rx_deframer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state, state_n;
  logic       rx_meta, rx_s;
  logic [3:0] sample, sample_n;
  logic [2:0] bitpos, bitpos_n;
  logic [7:0] shift, shift_n;
  logic [7:0] frame_byte;
  logic       frame_ok, frame_bad;
  logic [7:0] data_r;
  logic       rdy_r, ferr_r, ovr_r;

  // Idle-high reset value keeps a freshly reset receiver from seeing a false start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sample <= 4'd0;
      bitpos <= 3'd0;
      shift  <= 8'd0;
    end else begin
      state  <= state_n;
      sample <= sample_n;
      bitpos <= bitpos_n;
      shift  <= shift_n;
    end
  end

  always_comb begin
    state_n   = state;
    sample_n  = sample;
    bitpos_n  = bitpos;
    shift_n   = shift;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (bus.clken) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n  = START;
            sample_n = 4'd1;
          end
        end
        START: begin
          // A high tick before the 8th consecutive low one is treated as a glitch.
          if (rx_s) begin
            state_n = IDLE;
          end else if (sample == 4'd7) begin
            state_n  = DATA;
            sample_n = 4'd0;
            bitpos_n = 3'd0;
          end else begin
            sample_n = sample + 4'd1;
          end
        end
        DATA: begin
          if (sample == 4'd15) begin
            sample_n        = 4'd0;
            shift_n[bitpos] = rx_s;
            if (bitpos == LAST_BIT) state_n = STOP;
            else                    bitpos_n = bitpos + 3'd1;
          end else begin
            sample_n = sample + 4'd1;
          end
        end
        STOP: begin
          // Leaving at mid stop bit gives half a bit of slack to catch a back-to-back start.
          if (sample == 4'd15) begin
            sample_n  = 4'd0;
            state_n   = IDLE;
            frame_ok  = rx_s;
            frame_bad = !rx_s;
          end else begin
            sample_n = sample + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_byte                  = 8'd0;
    frame_byte[DATA_BITS-1:0]   = shift[DATA_BITS-1:0];
  end

  // A completing frame wins over the acknowledge for rdy; the acknowledge still wins for overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= 8'd0;
      rdy_r  <= 1'b0;
      ferr_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else if (frame_ok) begin
      data_r <= frame_byte;
      rdy_r  <= 1'b1;
      ferr_r <= 1'b0;
      ovr_r  <= bus.rdy_clr ? 1'b0 : (ovr_r | rdy_r);
    end else begin
      if (frame_bad) ferr_r <= 1'b1;
      if (bus.rdy_clr) begin
        rdy_r <= 1'b0;
        ovr_r <= 1'b0;
      end
    end
  end

  assign bus.data    = data_r;
  assign bus.rdy     = rdy_r;
  assign bus.ferr    = ferr_r;
  assign bus.overrun = ovr_r;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - randomized tick-level bench for uart_rx_deframer against a frame-scanning model
module tb_uart_rx_deframer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_rx_deframer_if bus ();

  uart_rx_deframer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Tick offsets from the first low tick of a start bit.
  localparam int FIRST_DATA = 23;
  localparam int MID_STOP   = 8 + 16 * 8 + 16 - 1;

  int         checks   = 0;
  int         failures = 0;
  int         cur_tick = 0;
  int         gap_min  = 4;
  int         gap_max  = 4;

  bit         wave[$];
  int         clr_list[$];
  int         ev_kind[$];
  logic [7:0] ev_byte[$];

  logic [7:0] m_data;
  bit         m_rdy, m_ferr, m_ovr;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s tick=%0d got=%0h expected=%0h", tag, cur_tick, got, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ".data"},    bus.data,           m_data);
    check_eq({where, ".rdy"},     {7'd0, bus.rdy},    {7'd0, m_rdy});
    check_eq({where, ".ferr"},    {7'd0, bus.ferr},   {7'd0, m_ferr});
    check_eq({where, ".overrun"}, {7'd0, bus.overrun}, {7'd0, m_ovr});
  endtask

  task automatic model_reset();
    m_data = 8'd0;
    m_rdy  = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic clear_plan();
    wave.delete();
    clr_list.delete();
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) wave.push_back(1'b1);
  endtask

  task automatic add_low(input int n);
    for (int i = 0; i < n; i++) wave.push_back(1'b0);
  endtask

  task automatic add_clr(input int t);
    clr_list.push_back(t);
  endtask

  // Stop level applies to the first half of the stop bit; the line is high afterwards.
  task automatic add_frame(input logic [7:0] b, input int p, input bit stop_lvl, output int start);
    logic [7:0] bv;
    bv    = b;
    start = wave.size();
    add_low(p);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < p; j++) wave.push_back(bv[k]);
    for (int j = 0; j < p; j++) wave.push_back((j < p / 2) ? stop_lvl : 1'b1);
  endtask

  function automatic bit is_clr(input int t);
    foreach (clr_list[i]) if (clr_list[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Reads frames straight off the tick waveform: 8 low ticks validate a start,
  // bits are read 16 ticks apart from mid start, the search resumes after mid stop.
  task automatic scan_wave();
    int         n, i, abort_at;
    logic [7:0] b;
    n = wave.size();
    ev_kind.delete();
    ev_byte.delete();
    for (int k = 0; k < n; k++) begin
      ev_kind.push_back(0);
      ev_byte.push_back(8'd0);
    end
    i = 0;
    while (i < n) begin
      if (wave[i]) begin
        i++;
      end else begin
        abort_at = -1;
        for (int k = 1; k < 8 && i + k < n; k++)
          if (abort_at < 0 && wave[i+k]) abort_at = i + k;
        if (abort_at >= 0) begin
          i = abort_at + 1;
        end else if (i + MID_STOP >= n) begin
          i = n;
        end else begin
          for (int k = 0; k < 8; k++) b[k] = wave[i + FIRST_DATA + 16 * k];
          ev_kind[i + MID_STOP] = wave[i + MID_STOP] ? 1 : 2;
          ev_byte[i + MID_STOP] = b;
          i = i + MID_STOP + 1;
        end
      end
    end
  endtask

  task automatic cycle(input bit ck, input bit clr, input int kind, input logic [7:0] b);
    bus.clken   = ck;
    bus.rdy_clr = clr;
    @(posedge clk);
    if (ck && kind == 1) begin
      m_ovr  = clr ? 1'b0 : (m_ovr | m_rdy);
      m_data = b;
      m_rdy  = 1'b1;
      m_ferr = 1'b0;
    end else begin
      if (ck && kind == 2) m_ferr = 1'b1;
      if (clr) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
    end
    #1;
    bus.clken   = 1'b0;
    bus.rdy_clr = 1'b0;
    @(negedge clk);
    check_outputs("run");
  endtask

  task automatic run_plan(input int limit);
    int gap;
    scan_wave();
    bus.rx = wave[0];
    for (int t = 0; t < limit && t < wave.size(); t++) begin
      cur_tick = t;
      gap = $urandom_range(gap_max, gap_min);
      for (int g = 0; g < gap - 1; g++) cycle(1'b0, 1'b0, 0, 8'd0);
      cycle(1'b1, is_clr(t), ev_kind[t], ev_byte[t]);
      if (t + 1 < wave.size()) bus.rx = wave[t+1];
    end
  endtask

  initial begin
    int         s;
    logic [7:0] basic [4];
    logic [7:0] rb;
    basic[0] = 8'h55; basic[1] = 8'h00; basic[2] = 8'hFF; basic[3] = 8'h80;

    bus.clken   = 1'b0;
    bus.rx      = 1'b1;
    bus.rdy_clr = 1'b0;
    reset       = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic frames at exactly 4 clk per tick.
    clear_plan();
    add_idle(4);
    for (int i = 0; i < 4; i++) begin
      add_frame(basic[i], 16, 1'b1, s);
      add_clr(s + MID_STOP + 20);
      add_idle(40);
    end
    run_plan(wave.size());

    // A frame that leaves rdy set, then reset partway through the next one.
    clear_plan();
    add_idle(4);
    add_frame(8'h6E, 16, 1'b1, s);
    add_idle(10);
    add_frame(8'hA5, 16, 1'b1, s);
    run_plan(s + 60);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("mid_reset");
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    gap_min = 3;
    gap_max = 6;
    clear_plan();
    add_idle(4);
    add_frame(8'h3C, 16, 1'b1, s);
    add_idle(20);
    // Short start glitch, then a real frame.
    add_low(5);
    add_idle(20);
    add_frame(8'hC3, 16, 1'b1, s);
    add_idle(30);
    // Framing error, then a good frame.
    add_frame(8'h12, 16, 1'b0, s);
    add_idle(30);
    add_frame(8'h34, 16, 1'b1, s);
    add_idle(30);
    // Break condition.
    add_low(320);
    add_idle(200);
    add_clr(wave.size());
    add_idle(20);
    // Back-to-back frames without acknowledge.
    add_frame(8'h11, 16, 1'b1, s);
    add_frame(8'h22, 16, 1'b1, s);
    add_idle(30);
    add_clr(wave.size());
    add_idle(20);
    // Acknowledge in the very tick the frame completes.
    add_frame(8'h99, 16, 1'b1, s);
    add_clr(s + MID_STOP);
    add_idle(30);
    run_plan(wave.size());

    // Bit period sweep, then random bytes with random acknowledges.
    clear_plan();
    add_idle(4);
    for (int p = 15; p <= 17; p++) begin
      add_frame(8'hA5, p, 1'b1, s);
      add_idle(40);
      add_clr(wave.size() - 5);
    end
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      add_frame(rb, 16, 1'($urandom_range(1, 0) | (i < 4)), s);
      if ($urandom_range(1, 0) == 1) add_clr(s + $urandom_range(MID_STOP + 2, MID_STOP - 2));
      add_idle($urandom_range(30, 0) + 10);
    end
    run_plan(wave.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
